dataram_arbiter: RTL and testbench

DATARAM_ARBITER -- requirements
Module: dataram_arbiter

---
 rtl/dataram_arbiter_pkg.sv | 32 +++
 rtl/dataram_arbiter_if.sv | 56 +++++
 rtl/dataram_prio_sel.sv | 21 ++
 rtl/dataram_arbiter.sv | 118 +++++++++++
 tb/tb_dataram_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/dataram_arbiter_pkg.sv
// Shared memory-side definitions: access owners, arbiter FSM states,
// grant vector bit positions and the load/store opcode constants.
package dataram_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_LD   = 2'd1,
    OWN_ST   = 2'd2,
    OWN_EXT  = 2'd3
  } owner_e;

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    LOCK_LD = 2'd1,
    LOCK_ST = 2'd2
  } arb_state_e;

  // Bit positions inside the one-hot grant vector {ext, st, ld}
  localparam int GNT_LD  = 0;
  localparam int GNT_ST  = 1;
  localparam int GNT_EXT = 2;

  localparam logic [2:0] LOAD_B  = 3'b000;
  localparam logic [2:0] LOAD_H  = 3'b001;
  localparam logic [2:0] LOAD_W  = 3'b010;
  localparam logic [2:0] LOAD_BU = 3'b100;
  localparam logic [2:0] LOAD_HU = 3'b101;
  localparam logic [2:0] STORE_B = 3'b000;
  localparam logic [2:0] STORE_H = 3'b001;
  localparam logic [2:0] STORE_W = 3'b010;

endpackage

// File: rtl/dataram_arbiter_if.sv
// Requester and SRAM-side signal bundle of the data RAM arbiter.
interface dataram_arbiter_if #(
  parameter int AW = 32
);
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic          ld_lock;
  logic          ld_gnt;
  logic          ld_rvalid;
  logic [31:0]   ld_rdata;

  logic          st_req;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_wdata;
  logic [3:0]    st_wstrb;
  logic          st_lock;
  logic          st_gnt;

  logic          ext_req;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [31:0]   ext_wdata;
  logic [3:0]    ext_wstrb;
  logic          ext_gnt;
  logic          ext_rvalid;
  logic [31:0]   ext_rdata;
  logic          ext_starved;

  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [3:0]    ram_wstrb;
  logic [31:0]   ram_rdata;

  modport slave (
    input  ld_req, ld_addr, ld_lock,
    input  st_req, st_addr, st_wdata, st_wstrb, st_lock,
    input  ext_req, ext_we, ext_addr, ext_wdata, ext_wstrb,
    input  ram_rdata,
    output ld_gnt, ld_rvalid, ld_rdata, st_gnt,
    output ext_gnt, ext_rvalid, ext_rdata, ext_starved,
    output ram_cs, ram_we, ram_addr, ram_wdata, ram_wstrb
  );

  modport master (
    output ld_req, ld_addr, ld_lock,
    output st_req, st_addr, st_wdata, st_wstrb, st_lock,
    output ext_req, ext_we, ext_addr, ext_wdata, ext_wstrb,
    output ram_rdata,
    input  ld_gnt, ld_rvalid, ld_rdata, st_gnt,
    input  ext_gnt, ext_rvalid, ext_rdata, ext_starved,
    input  ram_cs, ram_we, ram_addr, ram_wdata, ram_wstrb
  );

endinterface

// File: rtl/dataram_prio_sel.sv
// Fixed-priority pick among load, store and external requesters; a starved
// external requester jumps to the front of the queue.
module dataram_prio_sel
  import dataram_arbiter_pkg::*;
(
  input  logic       ld_req,
  input  logic       st_req,
  input  logic       ext_req,
  input  logic       starved,
  output logic [2:0] gnt
);

  always_comb begin
    gnt = '0;
    if (ext_req && starved) gnt[GNT_EXT] = 1'b1;
    else if (ld_req)        gnt[GNT_LD]  = 1'b1;
    else if (st_req)        gnt[GNT_ST]  = 1'b1;
    else if (ext_req)       gnt[GNT_EXT] = 1'b1;
  end

endmodule

// File: rtl/dataram_arbiter.sv
// Single-port data RAM arbiter: load/store/external requesters, lock hold for
// split accesses, starvation promotion for the external port, read return tag.
module dataram_arbiter
  import dataram_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 8,
  parameter int AW         = 32
) (
  input  logic              clk,
  input  logic              cpurst_n,
  dataram_arbiter_if.slave  bus
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  arb_state_e    state_q, state_d;
  owner_e        rd_tag_p1, rd_tag_p0;
  logic [CW-1:0] starve_cnt_q;
  logic          starved;
  logic [2:0]    sel_gnt;
  logic [2:0]    gnt;

  logic          ram_cs_c;
  logic          ram_we_c;
  logic [AW-1:0] ram_addr_c;
  logic [31:0]   ram_wdata_c;
  logic [3:0]    ram_wstrb_c;

  assign starved = (starve_cnt_q == CW'(STARVE_MAX));

  dataram_prio_sel u_prio_sel (
    .ld_req  (bus.ld_req),
    .st_req  (bus.st_req),
    .ext_req (bus.ext_req),
    .starved (starved),
    .gnt     (sel_gnt)
  );

  // While locked only the owner may be granted, and starvation cannot preempt it
  always_comb begin
    state_d = state_q;
    gnt     = '0;
    case (state_q)
      ARB: begin
        gnt = sel_gnt;
        if (sel_gnt[GNT_LD] && bus.ld_lock)      state_d = LOCK_LD;
        else if (sel_gnt[GNT_ST] && bus.st_lock) state_d = LOCK_ST;
      end
      LOCK_LD: begin
        gnt[GNT_LD] = bus.ld_req;
        if (!(bus.ld_req && bus.ld_lock)) state_d = ARB;
      end
      LOCK_ST: begin
        gnt[GNT_ST] = bus.st_req;
        if (!(bus.st_req && bus.st_lock)) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    ram_cs_c    = 1'b0;
    ram_we_c    = 1'b0;
    ram_addr_c  = '0;
    ram_wdata_c = '0;
    ram_wstrb_c = '0;
    rd_tag_p0   = OWN_NONE;
    if (gnt[GNT_LD]) begin
      ram_cs_c   = 1'b1;
      ram_addr_c = bus.ld_addr;
      rd_tag_p0  = OWN_LD;
    end else if (gnt[GNT_ST]) begin
      ram_cs_c    = 1'b1;
      ram_we_c    = 1'b1;
      ram_addr_c  = bus.st_addr;
      ram_wdata_c = bus.st_wdata;
      ram_wstrb_c = bus.st_wstrb;
    end else if (gnt[GNT_EXT]) begin
      ram_cs_c    = 1'b1;
      ram_we_c    = bus.ext_we;
      ram_addr_c  = bus.ext_addr;
      ram_wdata_c = bus.ext_wdata;
      ram_wstrb_c = bus.ext_wstrb;
      rd_tag_p0   = bus.ext_we ? OWN_NONE : OWN_EXT;
    end
  end

  // Stage p0 -> p1: grant decision registered as read-return owner
  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      state_q      <= ARB;
      rd_tag_p1    <= OWN_NONE;
      starve_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_tag_p1 <= rd_tag_p0;
      if (!bus.ext_req || gnt[GNT_EXT]) starve_cnt_q <= '0;
      else if (!starved)                starve_cnt_q <= starve_cnt_q + CW'(1);
    end
  end

  assign bus.ld_gnt      = gnt[GNT_LD];
  assign bus.st_gnt      = gnt[GNT_ST];
  assign bus.ext_gnt     = gnt[GNT_EXT];
  assign bus.ext_starved = starved;

  assign bus.ram_cs    = ram_cs_c;
  assign bus.ram_we    = ram_we_c;
  assign bus.ram_addr  = ram_addr_c;
  assign bus.ram_wdata = ram_wdata_c;
  assign bus.ram_wstrb = ram_wstrb_c;

  assign bus.ld_rvalid  = (rd_tag_p1 == OWN_LD);
  assign bus.ext_rvalid = (rd_tag_p1 == OWN_EXT);
  assign bus.ld_rdata   = bus.ld_rvalid  ? bus.ram_rdata : 32'h0;
  assign bus.ext_rdata  = bus.ext_rvalid ? bus.ram_rdata : 32'h0;

endmodule

// File: tb/tb_dataram_arbiter.sv
// Bench for dataram_arbiter: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model of the arbitration rules.
module tb_dataram_arbiter;

  localparam int SMAX = 8;

  logic clk = 1'b0;
  logic cpurst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dataram_arbiter_if #(.AW(32)) bus ();

  dataram_arbiter #(.STARVE_MAX(SMAX), .AW(32)) dut (
    .clk      (clk),
    .cpurst_n (cpurst_n),
    .bus      (bus)
  );

  task automatic idle_inputs();
    bus.ld_req = 0; bus.ld_addr = 0; bus.ld_lock = 0;
    bus.st_req = 0; bus.st_addr = 0; bus.st_wdata = 0; bus.st_wstrb = 0; bus.st_lock = 0;
    bus.ext_req = 0; bus.ext_we = 0; bus.ext_addr = 0; bus.ext_wdata = 0; bus.ext_wstrb = 0;
    bus.ram_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    cpurst_n = 1'b0;
    repeat (2) @(negedge clk);
    cpurst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    idle_inputs();
    cpurst_n = 1'b0;
    @(negedge clk);
    r = $urandom;
    bus.ld_req = 1; bus.ext_req = 1; bus.ram_rdata = r;
    @(negedge clk);
    #4;
    checks++; if (bus.ld_rvalid !== 1'b0) begin errors++; $display("FAIL reset_ld_rvalid: got %0b want 0", bus.ld_rvalid); end
    checks++; if (bus.ext_rvalid !== 1'b0) begin errors++; $display("FAIL reset_ext_rvalid: got %0b want 0", bus.ext_rvalid); end
    checks++; if (bus.ext_starved !== 1'b0) begin errors++; $display("FAIL reset_starved: got %0b want 0", bus.ext_starved); end
    checks++; if ({bus.ld_rdata, bus.ext_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", {bus.ld_rdata, bus.ext_rdata}); end
    do_reset();
  endtask

  task automatic test_priority();
    logic [31:0] r;
    do_reset();
    @(negedge clk);
    bus.ld_req = 1; bus.ld_addr = 32'h100; bus.st_req = 1; bus.st_addr = 32'h200; bus.ext_req = 1; bus.ext_addr = 32'h300;
    #4;
    checks++; if ({bus.ext_gnt, bus.st_gnt, bus.ld_gnt} !== 3'b001) begin errors++; $display("FAIL prio_gnt: got %b want 001", {bus.ext_gnt, bus.st_gnt, bus.ld_gnt}); end
    checks++; if ({bus.ram_cs, bus.ram_we, bus.ram_addr} !== {2'b10, 32'h100}) begin errors++; $display("FAIL prio_ram: got cs=%b we=%b addr=%h want cs=1 we=0 addr=100", bus.ram_cs, bus.ram_we, bus.ram_addr); end
    @(negedge clk);
    idle_inputs();
    r = $urandom; bus.ram_rdata = r;
    #4;
    checks++; if ({bus.ld_rvalid, bus.ext_rvalid} !== 2'b10) begin errors++; $display("FAIL prio_rvalid: got %b want 10", {bus.ld_rvalid, bus.ext_rvalid}); end
    checks++; if (bus.ld_rdata !== r) begin errors++; $display("FAIL prio_rdata: got %h want %h", bus.ld_rdata, r); end
  endtask

  task automatic test_lock();
    do_reset();
    @(negedge clk);
    bus.ld_req = 1; bus.ld_lock = 1; bus.ld_addr = 32'h103; bus.st_req = 1; bus.st_addr = 32'h40;
    #4;
    checks++; if ({bus.st_gnt, bus.ld_gnt, bus.ram_addr} !== {2'b01, 32'h103}) begin errors++; $display("FAIL lock_c1: got st=%b ld=%b addr=%h want st=0 ld=1 addr=103", bus.st_gnt, bus.ld_gnt, bus.ram_addr); end
    @(negedge clk);
    bus.ld_lock = 0; bus.ld_addr = 32'h104;
    #4;
    checks++; if ({bus.st_gnt, bus.ld_gnt, bus.ram_addr} !== {2'b01, 32'h104}) begin errors++; $display("FAIL lock_c2: got st=%b ld=%b addr=%h want st=0 ld=1 addr=104", bus.st_gnt, bus.ld_gnt, bus.ram_addr); end
    @(negedge clk);
    bus.ld_req = 0;
    #4;
    checks++; if ({bus.st_gnt, bus.ld_gnt} !== 2'b10) begin errors++; $display("FAIL lock_c3: got st=%b ld=%b want st=1 ld=0", bus.st_gnt, bus.ld_gnt); end
    // owner dropping its request while locked gives a dead cycle
    @(negedge clk);
    bus.st_req = 0; bus.ld_req = 1; bus.ld_lock = 1;
    @(negedge clk);
    bus.ld_req = 0; bus.ld_lock = 0; bus.st_req = 1;
    #4;
    checks++; if ({bus.st_gnt, bus.ld_gnt, bus.ram_cs} !== 3'b000) begin errors++; $display("FAIL lock_drop: got st=%b ld=%b cs=%b want all 0", bus.st_gnt, bus.ld_gnt, bus.ram_cs); end
    @(negedge clk);
    #4;
    checks++; if (bus.st_gnt !== 1'b1) begin errors++; $display("FAIL lock_after_drop: got st=%b want 1", bus.st_gnt); end
  endtask

  task automatic test_starve();
    logic [31:0] r;
    do_reset();
    for (int i = 1; i <= SMAX + 1; i++) begin
      @(negedge clk);
      bus.ld_req = 1; bus.ext_req = 1; bus.ext_we = 0; bus.ext_addr = 32'h500;
      #4;
      if (i <= SMAX) begin
        checks++; if ({bus.ext_starved, bus.ext_gnt} !== 2'b00) begin errors++; $display("FAIL starve_wait%0d: got starved=%b gnt=%b want 0 0", i, bus.ext_starved, bus.ext_gnt); end
      end else begin
        checks++; if ({bus.ext_starved, bus.ext_gnt, bus.ld_gnt} !== 3'b110) begin errors++; $display("FAIL starve_promote: got starved=%b ext=%b ld=%b want 1 1 0", bus.ext_starved, bus.ext_gnt, bus.ld_gnt); end
      end
    end
    @(negedge clk);
    r = $urandom; bus.ram_rdata = r;
    #4;
    checks++; if ({bus.ext_starved, bus.ld_gnt, bus.ext_rvalid} !== 3'b011) begin errors++; $display("FAIL starve_after: got starved=%b ld=%b ext_rvalid=%b want 0 1 1", bus.ext_starved, bus.ld_gnt, bus.ext_rvalid); end
    checks++; if (bus.ext_rdata !== r) begin errors++; $display("FAIL starve_rdata: got %h want %h", bus.ext_rdata, r); end
  endtask

  task automatic test_store();
    do_reset();
    @(negedge clk);
    bus.st_req = 1; bus.st_addr = 32'h80; bus.st_wdata = 32'hAABBCCDD; bus.st_wstrb = 4'b0110;
    #4;
    checks++; if ({bus.st_gnt, bus.ram_cs, bus.ram_we, bus.ram_wstrb, bus.ram_wdata, bus.ram_addr} !== {3'b111, 4'b0110, 32'hAABBCCDD, 32'h80}) begin
      errors++; $display("FAIL store_ram: got gnt=%b cs=%b we=%b strb=%b wdata=%h addr=%h", bus.st_gnt, bus.ram_cs, bus.ram_we, bus.ram_wstrb, bus.ram_wdata, bus.ram_addr); end
    @(negedge clk);
    idle_inputs(); bus.ram_rdata = 32'hDEADBEEF;
    #4;
    checks++; if ({bus.ld_rvalid, bus.ext_rvalid, bus.ld_rdata} !== 34'h0) begin errors++; $display("FAIL store_no_rvalid: got ld=%b ext=%b rdata=%h want 0", bus.ld_rvalid, bus.ext_rvalid, bus.ld_rdata); end
    checks++; if ({bus.ram_cs, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.ram_wstrb} !== 70'h0) begin errors++; $display("FAIL idle_ram: got cs=%b we=%b addr=%h", bus.ram_cs, bus.ram_we, bus.ram_addr); end
  endtask

  task automatic test_reset_lock();
    do_reset();
    @(negedge clk);
    bus.ld_req = 1; bus.ld_lock = 1; bus.ld_addr = 32'h200; bus.st_req = 1;
    #4;
    checks++; if (bus.ld_gnt !== 1'b1) begin errors++; $display("FAIL rstlock_gnt: got %b want 1", bus.ld_gnt); end
    @(negedge clk);
    bus.ld_addr = 32'h204;
    #2 cpurst_n = 1'b0;
    #2;
    checks++; if (bus.ld_rvalid !== 1'b0) begin errors++; $display("FAIL rstlock_rvalid: got %b want 0", bus.ld_rvalid); end
    @(negedge clk);
    cpurst_n = 1'b1; bus.ld_req = 0; bus.ld_lock = 0; bus.st_req = 1;
    #4;
    checks++; if ({bus.st_gnt, bus.ld_rvalid} !== 2'b10) begin errors++; $display("FAIL rstlock_resume: got st=%b ld_rvalid=%b want 1 0", bus.st_gnt, bus.ld_rvalid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      r = $urandom; bus.ram_rdata = r;
      bus.ld_req = (i < 5); bus.ld_addr = 32'h1000 + 32'(4 * i);
      #4;
      if (i < 5) begin
        checks++; if ({bus.ld_gnt, bus.ram_addr} !== {1'b1, 32'h1000 + 32'(4 * i)}) begin errors++; $display("FAIL b2b_gnt%0d: got gnt=%b addr=%h", i, bus.ld_gnt, bus.ram_addr); end
      end
      if (i > 0) begin
        checks++; if ({bus.ld_rvalid, bus.ld_rdata} !== {1'b1, r}) begin errors++; $display("FAIL b2b_rvalid%0d: got v=%b d=%h want 1 %h", i, bus.ld_rvalid, bus.ld_rdata, r); end
      end
    end
  endtask

  task automatic test_random();
    int m_lock, m_cnt, m_pend, eg;
    logic [31:0] r;
    logic [2:0]  exp_g;
    logic [69:0] exp_ram;
    do_reset();
    m_lock = 0; m_cnt = 0; m_pend = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      bus.ld_req  = (c < 300) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) != 0);
      bus.st_req  = ($urandom_range(0, 1) == 1);
      bus.ext_req = ($urandom_range(0, 2) != 0);
      bus.ld_lock = ($urandom_range(0, 3) == 0); bus.st_lock = ($urandom_range(0, 3) == 0);
      bus.ext_we  = ($urandom_range(0, 1) == 1);
      bus.ld_addr = $urandom; bus.st_addr = $urandom; bus.ext_addr = $urandom;
      bus.st_wdata = $urandom; bus.ext_wdata = $urandom;
      bus.st_wstrb = 4'($urandom); bus.ext_wstrb = 4'($urandom);
      r = $urandom; bus.ram_rdata = r;
      if (m_lock == 1)                      eg = bus.ld_req ? 1 : 0;
      else if (m_lock == 2)                 eg = bus.st_req ? 2 : 0;
      else if (bus.ext_req && m_cnt == SMAX) eg = 3;
      else if (bus.ld_req)                  eg = 1;
      else if (bus.st_req)                  eg = 2;
      else if (bus.ext_req)                 eg = 3;
      else                                  eg = 0;
      exp_g = (eg == 0) ? 3'b000 : 3'(1 << (eg - 1));
      case (eg)
        1:       exp_ram = {2'b10, bus.ld_addr, 32'h0, 4'h0};
        2:       exp_ram = {2'b11, bus.st_addr, bus.st_wdata, bus.st_wstrb};
        3:       exp_ram = {1'b1, bus.ext_we, bus.ext_addr, bus.ext_wdata, bus.ext_wstrb};
        default: exp_ram = '0;
      endcase
      #4;
      checks++; if ({bus.ext_gnt, bus.st_gnt, bus.ld_gnt} !== exp_g) begin errors++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, {bus.ext_gnt, bus.st_gnt, bus.ld_gnt}, exp_g); end
      checks++; if ({bus.ram_cs, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.ram_wstrb} !== exp_ram) begin
        errors++; $display("FAIL rnd_ram c%0d: got %h want %h", c, {bus.ram_cs, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.ram_wstrb}, exp_ram); end
      checks++; if ({bus.ld_rvalid, bus.ext_rvalid, bus.ld_rdata, bus.ext_rdata} !== {m_pend == 1, m_pend == 3, (m_pend == 1) ? r : 32'h0, (m_pend == 3) ? r : 32'h0}) begin
        errors++; $display("FAIL rnd_rd c%0d: got ld=%b ext=%b ldd=%h extd=%h pend_owner=%0d", c, bus.ld_rvalid, bus.ext_rvalid, bus.ld_rdata, bus.ext_rdata, m_pend); end
      checks++; if (bus.ext_starved !== (m_cnt == SMAX)) begin errors++; $display("FAIL rnd_starved c%0d: got %b want %b", c, bus.ext_starved, m_cnt == SMAX); end
      m_pend = (eg == 1) ? 1 : ((eg == 3 && !bus.ext_we) ? 3 : 0);
      if (m_lock == 1)      m_lock = (eg == 1 && bus.ld_lock) ? 1 : 0;
      else if (m_lock == 2) m_lock = (eg == 2 && bus.st_lock) ? 2 : 0;
      else                  m_lock = (eg == 1 && bus.ld_lock) ? 1 : ((eg == 2 && bus.st_lock) ? 2 : 0);
      m_cnt = (bus.ext_req && eg != 3) ? ((m_cnt < SMAX) ? m_cnt + 1 : SMAX) : 0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cpurst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_priority();
    test_lock();
    test_starve();
    test_store();
    test_reset_lock();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
